uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

- Command controller between the UART receiver, the register file and the UART transmitter.
- Consumes received bytes (one-cycle `rx_valid` pulses with `rx_data`) and assembles them into read/write command frames.
- Issues single-cycle register-file accesses and queues a one-byte response to the transmitter.
- Recovers from malformed or stalled frames by error response or inter-byte timeout.

## Interface

Parameters:
- ADDR_W, 4, register address width (16 registers)
- TIMEOUT_CYCLES, 8680, maximum clk cycles between bytes of one frame (≈2 byte times at 115200 baud / 50 MHz)

Ports:
- clk  input  1  system clock; one clock domain
- reset  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte, valid while rx_valid high
- rx_valid  input  1  one-cycle byte strobe from the receiver
- reg_addr  output  ADDR_W  register address
- reg_wr_data  output  8  write data
- reg_wr_en  output  1  one-cycle write strobe
- reg_rd_en  output  1  one-cycle read strobe
- reg_rd_data  input  8  read data, valid the cycle after reg_rd_en
- tx_data  output  8  response byte, held stable from tx_start until the next response
- tx_start  output  1  one-cycle transmit request
- tx_busy  input  1  transmitter busy
- cmd_error  output  1  one-cycle pulse on any rejected frame or timeout

## Operation

Frame formats:
- Write: 0x57 ('W'), addr, data → response 0x4B ('K').
- Read: 0x52 ('R'), addr → response is the register value.
- Rejected frame → response 0x45 ('E').

States and transitions:
- IDLE: opcode 0x57 or 0x52 → ADDR. Any other byte → ERR immediately.
- ADDR: latch the address. Address bits [7:ADDR_W] nonzero → ERR. Otherwise write → DATA; read → EXEC (or CSUM when enabled).
- DATA: latch data → EXEC (or CSUM when enabled).
- CSUM: see Configuration.
- EXEC: exactly one cycle.
  - Write: pulse reg_wr_en; tx_data ← 0x4B; → RESP.
  - Read: pulse reg_rd_en; → RD_WAIT.
- RD_WAIT: tx_data ← reg_rd_data; → RESP.
- ERR: pulse cmd_error; tx_data ← 0x45; → RESP.
- RESP: wait for tx_busy = 0, then pulse tx_start for one cycle → IDLE.

Boundary rules:
- rx_valid in EXEC, RD_WAIT, ERR or RESP: byte dropped, no state change.
- Inter-byte timeout:
  - Counter clears on each accepted byte and runs in ADDR, DATA and CSUM.
  - Reaching TIMEOUT_CYCLES−1 → pulse cmd_error and go to IDLE.
  - No response is sent on timeout.
- rx_valid in the same cycle as the timeout: the timeout wins and the byte is dropped.
- reg_wr_en and reg_rd_en are never high together and never high outside EXEC.
- Asynchronous reset mid-frame aborts the frame. No partial write is ever issued, because the write only occurs in EXEC.

## Timing

- Reset value 0 for every output, with state IDLE and the timeout counter at 0.
- Write: reg_wr_en is high 1 cycle after the rx_valid of the last frame byte.
- Read:
  - reg_rd_en is high 1 cycle after the last byte.
  - reg_rd_data is sampled 1 cycle later.
  - tx_start can first assert 3 cycles after the last byte.
- Error: tx_start can first assert 2 cycles after the offending byte.
- tx_start is delayed by however many cycles tx_busy remains high.
- reg_addr and reg_wr_data hold their last latched values between commands.

## Configuration

UART_CMD_CHECKSUM_EN:
- Defined:
  - Each frame carries a trailing checksum byte, equal to the XOR of all preceding frame bytes.
  - CSUM state compares it against a running XOR.
  - Mismatch → ERR, with no register access.
  - Latencies are measured from the checksum byte.
- Undefined:
  - No CSUM state and no XOR register.
  - The frame ends at the addr byte (read) or data byte (write).

## Structure

- Package uart_cmd_pkg holds:
  - opcode constants OP_WR = 8'h57 and OP_RD = 8'h52
  - response constants RSP_ACK = 8'h4B and RSP_ERR = 8'h45
  - the state encoding (IDLE, ADDR, DATA, CSUM, EXEC, RD_WAIT, ERR, RESP as 3-bit constants)
- One sub-module, uart_cmd_timeout, holds the inter-byte counter.
  - Inputs: clear, run.
  - Output: expired, a one-cycle pulse.
  - Width: $clog2(TIMEOUT_CYCLES).

## Test plan

- Write, checksum off: bytes 57 03 A5 → reg_wr_en one cycle with reg_addr = 3 and reg_wr_data = A5; then tx_start with tx_data = 4B.
- Read: preload reg 3 = A5; bytes 52 03 → reg_rd_en one cycle; tx_start with tx_data = A5, 3 cycles after the last byte.
- Rejections:
  - Byte 41 → cmd_error pulse and tx_data = 45, with no register strobe.
  - Bytes 52 13 (ADDR_W = 4) → error response.
- Timeout and busy:
  - Byte 57, then idle for TIMEOUT_CYCLES → cmd_error pulse, no tx_start; a following 52 00 executes normally.
  - With tx_busy held high for 100 cycles, tx_start is delayed until it falls.
- Checksum (UART_CMD_CHECKSUM_EN defined):
  - 57 03 A5 F1 → write accepted.
  - 57 03 A5 00 → 45 response, no reg_wr_en.
- Reset: assert reset after 57 03 → no reg_wr_en, all outputs 0; after release, 52 03 works.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command controller.
// Opcodes, response bytes and the 3-bit FSM state type live here.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    CSUM    = 3'd3,
    EXEC    = 3'd4,
    RD_WAIT = 3'd5,
    ERR     = 3'd6,
    RESP    = 3'd7
  } state_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: cleared by each accepted byte, counts while run is high,
// and pulses expired for one cycle when it reaches TIMEOUT_CYCLES-1.
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expired = run && (cnt == LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || !run || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command controller: assembles UART bytes into W/R frames, drives the register file
// and queues a one-byte response. Optional trailing XOR checksum via UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              cmd_error
);

`ifdef UART_CMD_CHECKSUM_EN
  localparam state_t FRAME_END = CSUM;
  logic [7:0] csum;
`else
  localparam state_t FRAME_END = EXEC;
`endif

  state_t state, state_nxt;
  logic   is_wr;
  logic   run;
  logic   timeout;
  logic   accept;
  logic   addr_ok;

  assign run     = (state == ADDR) || (state == DATA) || (state == CSUM);
  // A byte arriving on the timeout cycle is dropped: the timeout takes priority.
  assign accept  = rx_valid && ((state == IDLE) || run) && !timeout;
  assign addr_ok = (rx_data >> ADDR_W) == 8'd0;

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .run    (run),
    .expired(timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (rx_data == OP_WR || rx_data == OP_RD) ? ADDR : ERR;
      ADDR: begin
        if (timeout)     state_nxt = IDLE;
        else if (accept) state_nxt = !addr_ok ? ERR : (is_wr ? DATA : FRAME_END);
      end
      DATA: begin
        if (timeout)     state_nxt = IDLE;
        else if (accept) state_nxt = FRAME_END;
      end
`ifdef UART_CMD_CHECKSUM_EN
      CSUM: begin
        if (timeout)     state_nxt = IDLE;
        else if (accept) state_nxt = (rx_data == csum) ? EXEC : ERR;
      end
`endif
      EXEC:    state_nxt = is_wr ? RESP : RD_WAIT;
      RD_WAIT: state_nxt = RESP;
      ERR:     state_nxt = RESP;
      RESP:    if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_wr       <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      tx_data     <= '0;
    end else begin
      if (accept && state == IDLE) is_wr       <= (rx_data == OP_WR);
      if (accept && state == ADDR) reg_addr    <= rx_data[ADDR_W-1:0];
      if (accept && state == DATA) reg_wr_data <= rx_data;
      case (state)
        EXEC:    if (is_wr) tx_data <= RSP_ACK;
        RD_WAIT: tx_data <= reg_rd_data;
        ERR:     tx_data <= RSP_ERR;
        default: ;
      endcase
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  // Running XOR restarts on the opcode byte and excludes the checksum byte itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum <= '0;
    end else if (accept && state != CSUM) begin
      csum <= (state == IDLE) ? rx_data : (csum ^ rx_data);
    end
  end
`endif

  assign reg_wr_en = (state == EXEC) && is_wr;
  assign reg_rd_en = (state == EXEC) && !is_wr;
  assign tx_start  = (state == RESP) && !tx_busy;
  assign cmd_error = (state == ERR) || timeout;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl with a 16-entry register file model.
// Frames gain a trailing XOR byte automatically when UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_ctrl;

  localparam int ADDR_W = 4;
  localparam int TO     = 8680;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wr_data;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              cmd_error;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int err_cnt  = 0;
  int tx_cnt   = 0;
  int both_cnt = 0;

  logic [7:0] regs [16];

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_rd_data(reg_rd_data),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .cmd_error  (cmd_error)
  );

  // Register file model and strobe counters
  always @(posedge clk) begin
    if (reg_wr_en) regs[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= regs[reg_addr];
    if (reg_wr_en) wr_cnt++;
    if (reg_rd_en) rd_cnt++;
    if (cmd_error) err_cnt++;
    if (tx_start)  tx_cnt++;
    if (reg_wr_en && reg_rd_en) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int len);
    logic [7:0] x;
    x = b0;
    send_byte(b0);
    if (len > 1) begin x ^= b1; send_byte(b1); end
    if (len > 2) begin x ^= b2; send_byte(b2); end
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  // Latency counts negedges after the last byte's accepting edge, the first being 1.
  task automatic expect_resp(input string tag, input int lat_exp, input logic [7:0] data_exp);
    int lat;
    lat = -1;
    for (int n = 1; n <= 300; n++) begin
      if (tx_start) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_resp"}, tx_data, data_exp);
    @(negedge clk);
  endtask

  initial begin
    int w0, r0, e0, t0, lat, early;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_busy  = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_strobes", {reg_wr_en, reg_rd_en, tx_start, cmd_error}, 4'b0000);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_addr", reg_addr, 4'h0);
    check("rst_wr_data", reg_wr_data, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write 57 03 A5
    w0 = wr_cnt; r0 = rd_cnt;
    send_frame(8'h57, 8'h03, 8'hA5, 3);
    check("wr_strobe", {reg_wr_en, reg_rd_en}, 2'b10);
    check("wr_addr", reg_addr, 4'h3);
    check("wr_data", reg_wr_data, 8'hA5);
    expect_resp("wr", 2, 8'h4B);
    check("wr_count", wr_cnt - w0, 1);
    check("wr_no_rd", rd_cnt - r0, 0);

    // Read 52 03
    r0 = rd_cnt;
    send_frame(8'h52, 8'h03, 8'h00, 2);
    check("rd_strobe", {reg_wr_en, reg_rd_en}, 2'b01);
    expect_resp("rd", 3, 8'hA5);
    check("rd_count", rd_cnt - r0, 1);

    // Second pattern at the top address, and a value in register 0
    send_frame(8'h57, 8'h0F, 8'h3C, 3);
    expect_resp("wr_f", 2, 8'h4B);
    send_frame(8'h57, 8'h00, 8'h5A, 3);
    expect_resp("wr_0", 2, 8'h4B);
    send_frame(8'h52, 8'h0F, 8'h00, 2);
    expect_resp("rd_f", 3, 8'h3C);

    // Bad opcode
    e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h41);
    check("op_err_pulse", cmd_error, 1'b1);
    expect_resp("op_err", 2, 8'h45);
    check("op_err_count", err_cnt - e0, 1);
    check("op_err_no_reg", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // Address out of range
    e0 = err_cnt; w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h52);
    send_byte(8'h13);
    check("addr_err_pulse", cmd_error, 1'b1);
    expect_resp("addr_err", 2, 8'h45);
    check("addr_err_no_reg", (wr_cnt - w0) + (rd_cnt - r0), 0);

    // Inter-byte timeout after a lone opcode
    e0 = err_cnt; t0 = tx_cnt;
    send_byte(8'h57);
    lat = -1;
    for (int n = 1; n <= TO + 20; n++) begin
      if (cmd_error) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check("to_lat", lat, TO);
    repeat (10) @(negedge clk);
    check("to_err_count", err_cnt - e0, 1);
    check("to_no_tx", tx_cnt - t0, 0);
    send_frame(8'h52, 8'h00, 8'h00, 2);
    expect_resp("post_to", 3, 8'h5A);

    // Byte coinciding with the timeout is dropped
    send_byte(8'h57);
    repeat (TO - 1) @(negedge clk);
    check("to_coinc", cmd_error, 1'b1);
    send_byte(8'h00);
    repeat (2) @(negedge clk);
    e0 = err_cnt;
    send_frame(8'h52, 8'h03, 8'h00, 2);
    expect_resp("after_drop", 3, 8'hA5);
    check("after_drop_err", err_cnt - e0, 0);

    // Transmitter busy holds the response; a byte during RESP is dropped
    tx_busy = 1'b1;
    t0 = tx_cnt;
    send_byte(8'h41);
    early = 0;
    for (int i = 1; i <= 100; i++) begin
      if (tx_start) early++;
      if (i == 50) begin rx_data = 8'h57; rx_valid = 1'b1; end
      if (i == 51) rx_valid = 1'b0;
      @(negedge clk);
    end
    check("busy_hold", early, 0);
    tx_busy = 1'b0;
    #1;
    check("busy_release", tx_start, 1'b1);
    check("busy_resp", tx_data, 8'h45);
    @(negedge clk);
    check("busy_tx_count", tx_cnt - t0, 1);
    send_frame(8'h52, 8'h03, 8'h00, 2);
    expect_resp("post_busy", 3, 8'hA5);

`ifdef UART_CMD_CHECKSUM_EN
    w0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5); send_byte(8'hF1);
    check("cs_ok_strobe", reg_wr_en, 1'b1);
    expect_resp("cs_ok", 2, 8'h4B);
    check("cs_ok_count", wr_cnt - w0, 1);
    w0 = wr_cnt;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5); send_byte(8'h00);
    check("cs_bad_pulse", cmd_error, 1'b1);
    expect_resp("cs_bad", 2, 8'h45);
    check("cs_bad_no_wr", wr_cnt - w0, 0);
`endif

    // Reset mid-frame
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h03);
    reset = 1'b0;
    #1;
    check("mid_rst_strobes", {reg_wr_en, reg_rd_en, tx_start, cmd_error}, 4'b0000);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_addr", reg_addr, 4'h0);
    check("mid_rst_wr_data", reg_wr_data, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_wr", wr_cnt - w0, 0);
    send_frame(8'h52, 8'h03, 8'h00, 2);
    expect_resp("post_rst", 3, 8'hA5);

    check("strobe_excl", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
